// File: rtl/uart_tx_if.sv
// Parallel-word handshake and serial-line bundle for the UART transmitter.
// The master side supplies words; the slave side (uart_tx) owns the line.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  dout;
    logic                  busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  dout,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output dout,
        output busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART serialiser: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Bit timing comes from an internal clock-count, so no baud tick input is needed.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | line high, ready for a word
// S_START  | start bit (0) for CLKS_PER_BIT clocks
// S_DATA   | data bits, shift register LSB on the line
// S_PARITY | parity of the latched word (only when PARITY_EN)
// S_STOP   | STOP_BITS stop bits (1)
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [BAUD_W-1:0]     r_baud_cnt;
    logic                  r_parity;
    logic                  r_dout;

    logic                  w_bit_end;
    logic                  w_transfer;
    logic                  w_last_data;
    logic                  w_last_stop;

    assign w_bit_end   = (r_baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_transfer  = bus.in_valid && bus.in_ready;
    assign w_last_data = (r_bit_cnt == BIT_W'(DATA_WIDTH - 1));
    // The bit counter is reused to count stop bits.
    assign w_last_stop = (r_bit_cnt == BIT_W'(STOP_BITS - 1));

    assign bus.in_ready = (r_state == S_IDLE);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.dout     = r_dout;

    // Frame sequencer: state, baud counter, bit counter and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_parity   <= 1'b0;
        end else begin
            // Every non-idle state advances the baud counter the same way.
            if (r_state != S_IDLE) begin
                r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                    if (w_transfer) begin
                        r_shift  <= bus.in_data;
                        // Parity is taken from the word as latched, not from the shifting copy.
                        r_parity <= (^bus.in_data) ^ (PARITY_ODD != 0);
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (w_last_data) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_last_stop) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_bit_cnt  <= '0;
                    r_baud_cnt <= '0;
                end
            endcase
        end
    end

    // Registered line driver: decodes the current state, so the line lags the state by one clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout <= 1'b1;
        end else begin
            case (r_state)
                S_START:  r_dout <= 1'b0;
                S_DATA:   r_dout <= r_shift[0];
                S_PARITY: r_dout <= r_parity;
                default:  r_dout <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: three instances with different frame formats,
// checked against a frame model built from the protocol rules.
module tb_uart_tx;
    // Instance formats: 0 = defaults, 1 = 4 clk/bit + even parity, 2 = 2 clk/bit + 2 stop bits.
    localparam int CPB [3] = '{1, 4, 2};
    localparam int PEN [3] = '{0, 1, 0};
    localparam int PODD[3] = '{0, 0, 0};
    localparam int STP [3] = '{1, 1, 2};

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] d [3];
    logic       v [3];
    logic       w_dout [3];
    logic       w_rdy  [3];
    logic       w_busy [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_if #(.DATA_WIDTH(8)) if0 ();
    uart_tx_if #(.DATA_WIDTH(8)) if1 ();
    uart_tx_if #(.DATA_WIDTH(8)) if2 ();

    assign if0.in_data = d[0];
    assign if0.in_valid = v[0];
    assign if1.in_data = d[1];
    assign if1.in_valid = v[1];
    assign if2.in_data = d[2];
    assign if2.in_valid = v[2];
    assign w_dout[0] = if0.dout;
    assign w_rdy[0]  = if0.in_ready;
    assign w_busy[0] = if0.busy;
    assign w_dout[1] = if1.dout;
    assign w_rdy[1]  = if1.in_ready;
    assign w_busy[1] = if1.busy;
    assign w_dout[2] = if2.dout;
    assign w_rdy[2]  = if2.in_ready;
    assign w_busy[2] = if2.busy;

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    function automatic int frame_len(input int idx);
        return (1 + 8 + PEN[idx] + STP[idx]) * CPB[idx];
    endfunction

    // Sends one word on instance idx and checks the whole frame clock by clock.
    // mid_word is put on in_data right after the transfer edge; with hold_valid it is the next word.
    task automatic drive_frame(input int idx, input logic [7:0] word, input bit hold_valid,
                               input logic [7:0] mid_word, input string tag, output int t_start);
        int   n;
        int   f;
        int   cpb;
        bit   exp_bits[$];
        logic rx_bits[$];
        logic [2:0] exp_v;
        logic [2:0] got;
        logic [7:0] rx;
        f = frame_len(idx);
        cpb = CPB[idx];
        t_start = -1;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(word[i]);
        if (PEN[idx] != 0) exp_bits.push_back((^word) ^ (PODD[idx] != 0));
        for (int i = 0; i < STP[idx]; i++) exp_bits.push_back(1'b1);

        d[idx] = word;
        v[idx] = 1'b1;
        n = 0;
        while (w_rdy[idx] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL %s ready_timeout: in_ready=%b, required 1 within 1000 clocks", tag, w_rdy[idx]);
            v[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold_valid) v[idx] = 1'b0;
        d[idx] = mid_word;
        checks++;
        got = {w_dout[idx], w_rdy[idx], w_busy[idx]};
        if (got !== 3'b101) begin
            errors++;
            $display("FAIL %s accept {dout,ready,busy}: got %b, required 101", tag, got);
        end
        for (int k = 0; k < f; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) t_start = cyc;
            exp_v = {exp_bits[k / cpb], (k == f - 1), (k != f - 1)};
            got = {w_dout[idx], w_rdy[idx], w_busy[idx]};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL %s clk%0d {dout,ready,busy}: got %b, required %b", tag, k, got, exp_v);
            end
            if ((k % cpb) == (cpb / 2)) rx_bits.push_back(w_dout[idx]);
        end
        // Model receiver: mid-bit samples, LSB first after the start bit.
        rx = 8'h00;
        for (int i = 0; i < 8; i++) rx[i] = rx_bits[i + 1];
        checks++;
        if (rx !== word || rx_bits[0] !== 1'b0) begin
            errors++;
            $display("FAIL %s loopback: received %h start=%b, required %h start=0", tag, rx, rx_bits[0], word);
        end
    endtask

    task automatic test_reset();
        int ts;
        logic [2:0] got;
        reset = 1'b0;
        d[0] = 8'h5A;
        v[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                got = {w_dout[i], w_rdy[i], w_busy[i]};
                checks++;
                if (got !== 3'b110) begin
                    errors++;
                    $display("FAIL reset_hold u%0d {dout,ready,busy}: got %b, required 110", i, got);
                end
            end
        end
        reset = 1'b1;
        drive_frame(0, 8'h5A, 1'b0, 8'hC3, "reset_release", ts);
    endtask

    task automatic test_defaults();
        int ts;
        drive_frame(0, 8'hA5, 1'b0, 8'h00, "defaults_A5", ts);
    endtask

    task automatic test_parity();
        int ts;
        drive_frame(1, 8'h07, 1'b0, 8'hF8, "parity_07", ts);
        drive_frame(1, 8'h03, 1'b0, 8'h55, "parity_03", ts);
    endtask

    task automatic test_back_to_back(input int idx);
        int t0;
        int t1;
        int t2;
        int f;
        f = frame_len(idx);
        drive_frame(idx, 8'h00, 1'b1, 8'hFF, "b2b_00", t0);
        drive_frame(idx, 8'hFF, 1'b1, 8'h3C, "b2b_FF", t1);
        drive_frame(idx, 8'h3C, 1'b0, 8'($urandom), "b2b_3C", t2);
        checks++;
        if (t1 - t0 != f + 1 || t2 - t1 != f + 1) begin
            errors++;
            $display("FAIL b2b_spacing u%0d: got %0d and %0d clocks, required %0d", idx, t1 - t0, t2 - t1, f + 1);
        end
    endtask

    task automatic test_stop_reset();
        int ts;
        int n;
        logic [2:0] got;
        drive_frame(2, 8'($urandom), 1'b0, 8'($urandom), "stop2_rand", ts);
        drive_frame(2, 8'h80, 1'b0, 8'h7F, "stop2_80", ts);
        // Abandon a frame of zeros in the middle of its data bits.
        d[2] = 8'h00;
        v[2] = 1'b1;
        n = 0;
        while (w_rdy[2] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        v[2] = 1'b0;
        d[2] = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        got = {w_dout[2], w_rdy[2], w_busy[2]};
        checks++;
        if (got !== 3'b001) begin
            errors++;
            $display("FAIL mid_data {dout,ready,busy}: got %b, required 001", got);
        end
        #2;
        reset = 1'b0;
        #1;
        got = {w_dout[2], w_rdy[2], w_busy[2]};
        checks++;
        if (got !== 3'b110) begin
            errors++;
            $display("FAIL async_reset {dout,ready,busy}: got %b, required 110", got);
        end
        @(negedge clk);
        reset = 1'b1;
        drive_frame(2, 8'hB6, 1'b0, 8'h11, "after_reset", ts);
    endtask

    task automatic test_random();
        int ts;
        int idx;
        for (int it = 0; it < 12; it++) begin
            idx = int'($urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            drive_frame(idx, 8'($urandom), 1'b0, 8'($urandom), "random", ts);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            d[i] = 8'h00;
            v[i] = 1'b0;
        end
        test_reset();
        test_defaults();
        test_parity();
        test_back_to_back(0);
        test_back_to_back(1);
        test_stop_reset();
        test_random();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
